// File: rtl/adder_share_arbiter_if.sv
// Request/response bundle for the shared-adder arbiter.
// The master side is the requester pool plus result consumer; the slave side is the arbiter.
interface adder_share_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ-1:0]    req_cin;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [31:0]           resp_sum;
  logic                  resp_cout;

  modport master (
    output req_valid, req_a, req_b, req_cin, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_sum, resp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, resp_ready,
    output req_ready, resp_valid, resp_id, resp_sum, resp_cout
  );
endinterface

// File: rtl/adder_share_arbiter.sv
// Round-robin time-sharing of one 32-bit adder (two chained 16-bit slices) among NUM_REQ
// requesters; one operation in flight, result returned over a valid/ready channel.
module adder_share_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        reset,
  adder_share_arbiter_if.slave        bus,
  output logic                        busy,
  output logic [15:0]                 op_count
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q;
  logic [31:0]     a_q, b_q;
  logic            cin_q;
  logic [ID_W-1:0] gid_q;
  logic            resp_valid_q, resp_cout_q;
  logic [ID_W-1:0] resp_id_q;
  logic [31:0]     resp_sum_q;
  logic [15:0]     op_count_q;
  logic            busy_q;

  logic            gnt_found;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W:0]   cand;
  logic [31:0]     sel_a, sel_b;
  logic            sel_cin;
  logic            accept, handshake;
  logic [16:0]     lo_sum, hi_sum;

  // First valid requester at or after rr_ptr, searching upward with wrap.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (!gnt_found && bus.req_valid[cand[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        sel_a   = bus.req_a[i*32 +: 32];
        sel_b   = bus.req_b[i*32 +: 32];
        sel_cin = bus.req_cin[i];
      end
    end
  end

  // Shared adder: the high slice consumes the low slice's carry.
  always_comb begin
    lo_sum = {1'b0, a_q[15:0]} + {1'b0, b_q[15:0]} + 17'(cin_q);
    hi_sum = {1'b0, a_q[31:16]} + {1'b0, b_q[31:16]} + 17'(lo_sum[16]);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (gnt_found) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (bus.resp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    accept        = (state_q == StIdle) && gnt_found && !reset;
    handshake     = (state_q == StResp) && bus.resp_ready;
    bus.req_ready = '0;
    if (accept) begin
      bus.req_ready[gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      a_q          <= '0;
      b_q          <= '0;
      cin_q        <= 1'b0;
      gid_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_sum_q   <= '0;
      resp_cout_q  <= 1'b0;
      op_count_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != StIdle);
      if (accept) begin
        a_q      <= sel_a;
        b_q      <= sel_b;
        cin_q    <= sel_cin;
        gid_q    <= gnt_idx;
        rr_ptr_q <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
      end
      if (state_q == StExec) begin
        resp_valid_q <= 1'b1;
        resp_id_q    <= gid_q;
        resp_sum_q   <= {hi_sum[15:0], lo_sum[15:0]};
        resp_cout_q  <= hi_sum[16];
      end
      if (handshake) begin
        resp_valid_q <= 1'b0;
        op_count_q   <= op_count_q + 16'd1;
      end
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_sum   = resp_sum_q;
  assign bus.resp_cout  = resp_cout_q;
  assign busy           = busy_q;
  assign op_count       = op_count_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: directed literal cases plus randomized traffic, with every
// cycle compared against a transaction-level model of the arbiter.
module tb_adder_share_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        busy;
  logic [15:0] op_count;

  adder_share_arbiter_if #(.NUM_REQ(N), .ID_W(IW)) bus ();

  adder_share_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // Model state: one op in flight, described by age since accept.
  int          m_ptr = 0;
  bit          m_inflight = 1'b0;
  int          m_age = 0;
  logic [31:0] m_a = '0, m_b = '0;
  logic        m_cin = 1'b0;
  int          m_g = 0;
  bit          m_rv = 1'b0;
  int          m_rid = 0;
  logic [32:0] m_res = '0;
  int unsigned m_cnt = 0;
  int          m_last = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin : model
    int g;
    @(posedge clk);
    m_last = -1;
    if (reset) begin
      m_ptr = 0; m_inflight = 1'b0; m_rv = 1'b0; m_rid = 0; m_res = '0; m_cnt = 0;
    end else if (!m_inflight) begin
      g = pick(bus.req_valid, m_ptr);
      if (g >= 0) begin
        m_a = bus.req_a[g*32 +: 32];
        m_b = bus.req_b[g*32 +: 32];
        m_cin = bus.req_cin[g];
        m_g = g;
        m_inflight = 1'b1;
        m_age = 0;
        m_ptr = (g + 1) % N;
        m_last = g;
      end
    end else if (m_age == 0) begin
      m_rv = 1'b1;
      m_rid = m_g;
      m_res = {1'b0, m_a} + {1'b0, m_b} + 33'(m_cin);
      m_age = 1;
    end else if (bus.resp_ready) begin
      m_rv = 1'b0;
      m_cnt++;
      m_inflight = 1'b0;
    end
  end

  initial forever begin : compare
    logic [N-1:0] exp_rdy;
    int g;
    @(negedge clk);
    if (chk_en) begin
      exp_rdy = '0;
      if (!reset && !m_inflight) begin
        g = pick(bus.req_valid, m_ptr);
        if (g >= 0) exp_rdy[g] = 1'b1;
      end
      chk("req_ready", bus.req_ready, exp_rdy);
      chk("resp_valid", bus.resp_valid, m_rv);
      chk("busy", busy, m_inflight);
      chk("op_count", op_count, m_cnt[15:0]);
      if (m_rv) begin
        chk("resp_id", bus.resp_id, m_rid);
        chk("resp_sum", bus.resp_sum, m_res[31:0]);
        chk("resp_cout", bus.resp_cout, m_res[32]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic c);
    bus.req_a[i*32 +: 32] = a;
    bus.req_b[i*32 +: 32] = b;
    bus.req_cin[i] = c;
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Waits (at negedges) for a grant to requester i, bounded.
  task automatic wait_grant(input int i);
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready[i] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("grant_wait", (n < 20), 1);
  endtask

  task automatic wait_resp();
    int n = 0;
    @(negedge clk);
    while (!bus.resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("resp_wait", (n < 20), 1);
  endtask

  task automatic run_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic c, output logic [32:0] res, output int id);
    set_req(i, a, b, c);
    bus.req_valid[i] = 1'b1;
    wait_grant(i);
    step();
    bus.req_valid[i] = 1'b0;
    wait_resp();
    res = {bus.resp_cout, bus.resp_sum};
    id = int'(bus.resp_id);
    step();
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [32:0] r;
    int id;
    int prev;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_cin = '0;
    bus.resp_ready = 1'b1;
    reset = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    step();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_resp_sum", bus.resp_sum, 0);
    chk("rst_resp_id", bus.resp_id, 0);

    // Single op from requester 2: grant in accept cycle, result two cycles later
    step();
    set_req(2, 32'h0000_FFFF, 32'h0000_0001, 1'b0);
    bus.req_valid = 4'b0100;
    @(negedge clk);
    chk("single_grant", bus.req_ready, 4'b0100);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    chk("single_exec_valid", bus.resp_valid, 0);
    chk("single_exec_busy", busy, 1);
    step();
    @(negedge clk);
    chk("single_valid", bus.resp_valid, 1);
    chk("single_id", bus.resp_id, 2);
    chk("single_sum", bus.resp_sum, 32'h0001_0000);
    chk("single_cout", bus.resp_cout, 0);
    step();
    @(negedge clk);
    chk("single_count", op_count, 1);
    chk("single_done", bus.resp_valid, 0);

    // Carry and wrap cases
    run_op(0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, r, id);
    chk("carry_wrap", r, 33'h1_0000_0000);
    run_op(1, 32'h8000_0000, 32'h8000_0000, 1'b0, r, id);
    chk("msb_carry", r, 33'h1_0000_0000);
    run_op(3, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, r, id);
    chk("slice_carry", r, 33'h0_ACF1_3569);
    chk("slice_id", id, 3);

    // Round robin with all requesters continuously valid
    for (int i = 0; i < N; i++) set_req(i, $urandom, $urandom, 1'($urandom % 2));
    bus.req_valid = 4'b1111;
    prev = 0;
    for (int k = 0; k < 8; k++) begin
      wait_resp();
      chk("rr_id", bus.resp_id, k % N);
      if (k > 0) chk("rr_interval", cyc - prev, 3);
      prev = cyc;
    end
    step();
    bus.req_valid = '0;
    step();

    // Backpressure
    bus.resp_ready = 1'b0;
    set_req(1, 32'h1111_1111, 32'h2222_2222, 1'b1);
    bus.req_valid = 4'b0010;
    wait_grant(1);
    step();
    bus.req_valid = 4'b1111;
    wait_resp();
    for (int j = 0; j < 10; j++) begin
      chk("bp_valid", bus.resp_valid, 1);
      chk("bp_id", bus.resp_id, 1);
      chk("bp_sum", bus.resp_sum, 32'h3333_3334);
      chk("bp_no_grant", bus.req_ready, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #2;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_released", bus.resp_valid, 0);
    chk("bp_next_grant", bus.req_ready, 4'b0100);
    step();
    bus.req_valid = '0;
    repeat (4) step();

    // Reset during EXEC
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_req(2, 32'hDEAD_BEEF, 32'h1, 1'b0);
    bus.req_valid = 4'b0100;
    @(negedge clk);
    chk("mid_grant", bus.req_ready, 4'b0100);
    step();
    bus.req_valid = '0;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_exec_busy", busy, 1);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_valid", bus.resp_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_count", op_count, 0);
    step();
    set_req(1, 32'h5, 32'h6, 1'b0);
    set_req(3, 32'h7FFF_FFFF, 32'h1, 1'b0);
    bus.req_valid = 4'b1010;
    @(negedge clk);
    chk("mid_ptr_reset", bus.req_ready, 4'b0010);
    step();
    bus.req_valid = 4'b1000;
    wait_grant(3);
    step();
    bus.req_valid = '0;
    wait_resp();
    chk("mid_r3_id", bus.resp_id, 3);
    chk("mid_r3_sum", bus.resp_sum, 32'h8000_0000);
    chk("mid_r3_cout", bus.resp_cout, 0);
    step();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[i] && m_last == i) begin
          bus.req_valid[i] = 1'($urandom % 2);
          set_req(i, rnd_op(), rnd_op(), 1'($urandom % 2));
        end else if (!bus.req_valid[i]) begin
          if ($urandom % 3 == 0) begin
            set_req(i, rnd_op(), rnd_op(), 1'($urandom % 2));
            bus.req_valid[i] = 1'b1;
          end
        end else if ($urandom % 40 == 0) begin
          bus.req_valid[i] = 1'b0;
        end
      end
      bus.resp_ready = ($urandom % 4) != 0;
      reset = ($urandom % 300) == 0;
    end
    reset = 1'b0;
    bus.req_valid = '0;
    bus.resp_ready = 1'b1;
    repeat (6) step();
    chk("final_idle", busy, 0);
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
